// File: rtl/axis_sa_transpose_if.sv
// -----------------------------------------------------------------------------
// axis_sa_transpose_if
// Purpose : AXI-Stream style beat bus carrying N words of WY bits plus framing.
// Signals : valid - beat valid (master -> slave)
//           ready - beat accepted when valid & ready (slave -> master)
//           data  - [N-1:0][WY-1:0] payload words
//           last  - final beat of a frame
// -----------------------------------------------------------------------------
interface axis_sa_transpose_if #(
   parameter int unsigned N  = 2,
   parameter int unsigned WY = 11
) ();
   logic                 valid;
   logic                 ready;
   logic [N-1:0][WY-1:0] data;
   logic                 last;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/axis_sa_transpose.sv
// -----------------------------------------------------------------------------
// axis_sa_transpose
// Purpose : Double-buffered transpose of systolic-array output tiles. Accepts C
//           column beats of R words each and re-emits the tile as R row beats
//           of C words each, row 0 first, m.last on the final row.
// Ports   : clk  - clock, rising edge
//           rst  - synchronous reset, active-high
//           s    - slave stream, one tile column per beat (data word r = row r)
//           m    - master stream, one tile row per beat (data word c = column c)
//           err  - sticky framing error (s.last misplaced), cleared by rst
// -----------------------------------------------------------------------------
module axis_sa_transpose #(
   parameter int unsigned R           = 2,
   parameter int unsigned C           = 2,
   parameter int unsigned WY          = 11,
   parameter bit          COL_REVERSE = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   axis_sa_transpose_if.slave  s,
   axis_sa_transpose_if.master m,
   output logic                err
);

   localparam int unsigned RW = (R > 1) ? $clog2(R) : 1;
   localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;

   // Tile storage: two banks, not reset (contents are only exposed once a bank is full)
   logic [WY-1:0] bank_q [2][R][C];

   logic [1:0]    full_q,    full_n;
   logic          wr_bank_q, wr_bank_n;
   logic          rd_bank_q, rd_bank_n;
   logic [CW-1:0] wcol_q,    wcol_n;
   logic [RW-1:0] rrow_q,    rrow_n;
   logic          err_n;
   logic          s_ready_q, s_ready_n;
   logic          m_valid_q, m_valid_n;
   logic          m_last_q,  m_last_n;

   logic          s_fire_c;
   logic          m_fire_c;
   logic          wcol_last_c;
   logic          rrow_last_c;
   logic [CW-1:0] wr_col_c;

   // s_ready_q always mirrors !full_q[wr_bank_q] outside reset, so it gates acceptance directly
   assign s_fire_c    = s.valid & s_ready_q;
   assign m_fire_c    = m_valid_q & m.ready;
   assign wcol_last_c = (wcol_q == CW'(C - 1));
   assign rrow_last_c = (rrow_q == RW'(R - 1));
   assign wr_col_c    = COL_REVERSE ? (CW'(C - 1) - wcol_q) : wcol_q;

   assign s.ready = s_ready_q;
   assign m.valid = m_valid_q;
   assign m.last  = m_last_q;

   // Output row is a pure mux of bank registers, so no s -> m combinational path exists
   for (genvar gc = 0; gc < int'(C); gc++) begin : g_mdata
      assign m.data[gc] = bank_q[rd_bank_q][rrow_q][gc];
   end

   // Next-state: write-side column counter, read-side row counter, bank flags
   always_comb begin
      full_n    = full_q;
      wr_bank_n = wr_bank_q;
      rd_bank_n = rd_bank_q;
      wcol_n    = wcol_q;
      rrow_n    = rrow_q;
      err_n     = err;

      if (s_fire_c) begin
         // Tile always closes on the C-th beat; a misplaced or missing last only flags
         if (s.last != wcol_last_c) begin
            err_n = 1'b1;
         end
         if (wcol_last_c) begin
            wcol_n            = '0;
            full_n[wr_bank_q] = 1'b1;
            wr_bank_n         = ~wr_bank_q;
         end else begin
            wcol_n = wcol_q + CW'(1);
         end
      end

      // Reader only touches a full bank and writer only a non-full one, so flags never collide
      if (m_fire_c) begin
         if (rrow_last_c) begin
            rrow_n            = '0;
            full_n[rd_bank_q] = 1'b0;
            rd_bank_n         = ~rd_bank_q;
         end else begin
            rrow_n = rrow_q + RW'(1);
         end
      end

      s_ready_n = ~full_n[wr_bank_n];
      m_valid_n = full_n[rd_bank_n];
      m_last_n  = full_n[rd_bank_n] & (rrow_n == RW'(R - 1));
   end

   // Control state register
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wcol_q    <= '0;
         rrow_q    <= '0;
         err       <= 1'b0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
      end else begin
         full_q    <= full_n;
         wr_bank_q <= wr_bank_n;
         rd_bank_q <= rd_bank_n;
         wcol_q    <= wcol_n;
         rrow_q    <= rrow_n;
         err       <= err_n;
         s_ready_q <= s_ready_n;
         m_valid_q <= m_valid_n;
         m_last_q  <= m_last_n;
      end
   end

   // Column write into the current write bank
   always_ff @(posedge clk) begin
      if (s_fire_c) begin
         for (int r = 0; r < int'(R); r++) begin
            bank_q[wr_bank_q][r][wr_col_c] <= s.data[r];
         end
      end
   end

endmodule
